mips_muldiv_unit: RTL and testbench

Iterative multiply/divide unit for the EX stage of the pipelined MIPS core, holding the architectural HI/LO registers.
- Executes MULT, MULTU, DIV, DIVU as shift-add and restoring-subtract loops, one step per cycle.
- Drives a 32-bit adder datapath with carry-in. Subtraction is A + ~B + 1, and the adder carry-out is the unsigned borrow/compare result.
- Also services MTHI/MTLO. The pipeline control uses busy to stall MFHI/MFLO and new mult/div ops.

---
 rtl/mips_muldiv_unit.sv | 198 +++++++++++++++++++
 tb/tb_mips_muldiv_unit.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mips_muldiv_unit.sv
// Iterative multiply/divide unit for the MIPS EX stage. Holds the HI/LO
// architectural registers. MULT/MULTU use a shift-add loop and DIV/DIVU use a
// restoring-subtract loop, one bit per cycle. MTHI/MTLO write HI/LO directly
// while the unit is idle.

module mips_muldiv_unit #(
    parameter int unsigned WIDTH      = 32,
    parameter bit          DIV0_WRITE = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             div0,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    typedef enum logic [2:0] {
        StIdle,
        StPrep,
        StRun,
        StFix,
        StDone
    } state_e;

    state_e            state_q;
    logic [CntW-1:0]   cnt_q;
    logic              is_div_q;
    logic              sign_x_q;   // sign of opx_q (multiplicand / divisor)
    logic              sign_r_q;   // sign of rlo_q at latch (multiplier / dividend)
    logic [WIDTH-1:0]  opx_q;      // multiplicand or divisor
    logic [WIDTH-1:0]  rhi_q;      // partial product upper half or remainder
    logic [WIDTH-1:0]  rlo_q;      // multiplier / product low half or quotient
    logic [WIDTH-1:0]  hi_q;
    logic [WIDTH-1:0]  lo_q;
    logic              done_q;
    logic              div0_q;

    logic              op_signed;
    logic              op_is_div;

    logic [WIDTH:0]    neg_x_sum;
    logic [WIDTH:0]    neg_r_sum;
    logic [WIDTH:0]    mul_sum;
    logic [WIDTH-1:0]  rem_sh;
    logic              rem_top;
    logic [WIDTH:0]    div_sum;
    logic              div_ge;
    logic [WIDTH:0]    lo_neg_sum;
    logic [WIDTH:0]    hi_neg_sum;
    logic [WIDTH:0]    rem_neg_sum;
    logic              unused_carry;

    // Unsigned adder with carry-in; subtraction is x + ~y + 1.
    function automatic logic [WIDTH:0] add(input logic [WIDTH-1:0] x,
                                           input logic [WIDTH-1:0] y,
                                           input logic             cin);
        add = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
    endfunction

    assign op_signed = ~op[0];
    assign op_is_div = op[1];

    // Adder datapath for abs-value prep, loop steps and final sign fix-up.
    always_comb begin
        neg_x_sum   = add('0, ~opx_q, 1'b1);
        neg_r_sum   = add('0, ~rlo_q, 1'b1);
        mul_sum     = add(rhi_q, rlo_q[0] ? opx_q : '0, 1'b0);
        rem_sh      = {rhi_q[WIDTH-2:0], rlo_q[WIDTH-1]};
        rem_top     = rhi_q[WIDTH-1];
        div_sum     = add(rem_sh, ~opx_q, 1'b1);
        // The shifted remainder is WIDTH+1 bits wide; a set top bit always fits.
        div_ge      = div_sum[WIDTH] | rem_top;
        lo_neg_sum  = add('0, ~rlo_q, 1'b1);
        hi_neg_sum  = add('0, ~rhi_q, lo_neg_sum[WIDTH]);
        rem_neg_sum = add('0, ~rhi_q, 1'b1);
    end

    assign unused_carry = ^{neg_x_sum[WIDTH], neg_r_sum[WIDTH], hi_neg_sum[WIDTH],
                            rem_neg_sum[WIDTH]};

    // Control FSM, operand latches, iteration datapath and HI/LO commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            sign_x_q <= 1'b0;
            sign_r_q <= 1'b0;
            opx_q    <= '0;
            rhi_q    <= '0;
            rlo_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            div0_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            div0_q <= 1'b0;
            if (flush) begin
                // Aborts any running op; in IDLE it also masks a coincident start.
                state_q <= StIdle;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (start) begin
                            case (op)
                                3'b100: hi_q <= a;
                                3'b101: lo_q <= a;
                                3'b000, 3'b001, 3'b010, 3'b011: begin
                                    is_div_q <= op_is_div;
                                    rhi_q    <= '0;
                                    cnt_q    <= '0;
                                    if (op_is_div) begin
                                        rlo_q    <= a;
                                        opx_q    <= b;
                                        sign_r_q <= op_signed & a[WIDTH-1];
                                        sign_x_q <= op_signed & b[WIDTH-1];
                                    end else begin
                                        rlo_q    <= b;
                                        opx_q    <= a;
                                        sign_r_q <= op_signed & b[WIDTH-1];
                                        sign_x_q <= op_signed & a[WIDTH-1];
                                    end
                                    if (op_is_div && (b == '0)) begin
                                        state_q <= StDone;
                                        done_q  <= 1'b1;
                                        div0_q  <= 1'b1;
                                        if (DIV0_WRITE) begin
                                            lo_q <= '1;
                                            hi_q <= a;
                                        end
                                    end else begin
                                        state_q <= StPrep;
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end
                    StPrep: begin
                        if (sign_x_q) opx_q <= neg_x_sum[WIDTH-1:0];
                        if (sign_r_q) rlo_q <= neg_r_sum[WIDTH-1:0];
                        cnt_q   <= '0;
                        state_q <= StRun;
                    end
                    StRun: begin
                        if (is_div_q) begin
                            rhi_q <= div_ge ? div_sum[WIDTH-1:0] : rem_sh;
                            rlo_q <= {rlo_q[WIDTH-2:0], div_ge};
                        end else begin
                            rhi_q <= mul_sum[WIDTH:1];
                            rlo_q <= {mul_sum[0], rlo_q[WIDTH-1:1]};
                        end
                        cnt_q <= cnt_q + CntW'(1);
                        if (cnt_q == CntLast) state_q <= StFix;
                    end
                    StFix: begin
                        if (is_div_q) begin
                            lo_q <= (sign_x_q ^ sign_r_q) ? lo_neg_sum[WIDTH-1:0] : rlo_q;
                            hi_q <= sign_r_q ? rem_neg_sum[WIDTH-1:0] : rhi_q;
                        end else if (sign_x_q ^ sign_r_q) begin
                            hi_q <= hi_neg_sum[WIDTH-1:0];
                            lo_q <= lo_neg_sum[WIDTH-1:0];
                        end else begin
                            hi_q <= rhi_q;
                            lo_q <= rlo_q;
                        end
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end
                    StDone: begin
                        state_q <= StIdle;
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

    assign busy = (state_q != StIdle);
    assign done = done_q;
    assign div0 = div0_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Directed bench for mips_muldiv_unit. Two instances share the stimulus; the
// second one writes HI/LO on divide-by-zero. Cycle 0 is the cycle in which start
// is presented; cycle n follows the n-th rising edge after it.

module tb_mips_muldiv_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        busy, done, div0;
    logic [31:0] hi, lo;
    logic        busy_w, done_w, div0_w;
    logic [31:0] hi_w, lo_w;

    int n_checks;
    int n_errors;
    int cyc;

    mips_muldiv_unit #(.WIDTH(32), .DIV0_WRITE(1'b0)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .div0  (div0),
        .hi    (hi),
        .lo    (lo)
    );

    mips_muldiv_unit #(.WIDTH(32), .DIV0_WRITE(1'b1)) u_dut_w (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .flush (flush),
        .busy  (busy_w),
        .done  (done_w),
        .div0  (div0_w),
        .hi    (hi_w),
        .lo    (lo_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled on falling edges only.
    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
        start = 1'b1;
        op    = o;
        a     = av;
        b     = bv;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
    endtask

    task automatic wait_done(input string tag, input int exp_cyc,
                             input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int dc;
        int gaps;
        dc   = -1;
        gaps = 0;
        while (cyc < 60) begin
            if (!busy) gaps++;
            if (done) begin
                dc = cyc;
                break;
            end
            step();
        end
        check({tag, " done_cycle"}, dc, exp_cyc);
        check({tag, " busy_gaps"}, gaps, 0);
        check({tag, " div0"}, div0, 1'b0);
        check({tag, " hi"}, hi, exp_hi);
        check({tag, " lo"}, lo, exp_lo);
        step();
        check({tag, " done_clear"}, {busy, done}, 2'b00);
    endtask

    task automatic count_done(input int n, output int nd);
        nd = 0;
        for (int i = 0; i < n; i++) begin
            if (done) nd++;
            step();
        end
    endtask

    initial begin
        int nd;
        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        flush    = 1'b0;
        op       = 3'b000;
        a        = '0;
        b        = '0;
        repeat (2) @(negedge clk);
        check("reset ctl", {busy, done, div0}, 3'b000);
        check("reset hi", hi, 32'h0);
        check("reset lo", lo, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("multu max", 35, 32'hFFFF_FFFE, 32'h0000_0001);

        issue(3'b000, 32'hFFFF_FFFD, 32'd5);
        wait_done("mult neg", 35, 32'hFFFF_FFFF, 32'hFFFF_FFF1);

        issue(3'b010, 32'hFFFF_FFF9, 32'd2);
        wait_done("div neg", 35, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("div ovf", 35, 32'h0, 32'h8000_0000);

        issue(3'b011, 32'd100, 32'd7);
        wait_done("divu", 35, 32'd2, 32'd14);

        issue(3'b100, 32'h11, 32'h0);
        check("mthi hi", hi, 32'h11);
        check("mthi ctl", {busy, done}, 2'b00);
        issue(3'b101, 32'h22, 32'h0);
        check("mtlo lo", lo, 32'h22);
        check("mtlo hi", hi, 32'h11);

        flush = 1'b1;
        issue(3'b100, 32'hDEAD, 32'h0);
        flush = 1'b0;
        check("flush idle mthi", hi, 32'h11);

        issue(3'b011, 32'h55, 32'h0);
        check("div0 ctl", {done, div0}, 2'b11);
        check("div0 keep hi", hi, 32'h11);
        check("div0 keep lo", lo, 32'h22);
        check("div0w ctl", {done_w, div0_w}, 2'b11);
        check("div0w hi", hi_w, 32'h55);
        check("div0w lo", lo_w, 32'hFFFF_FFFF);
        step();
        check("div0 clear", {busy, done, div0}, 3'b000);

        issue(3'b001, 32'h1234_5678, 32'h10);
        while (cyc < 5) step();
        start = 1'b1;
        op    = 3'b011;
        a     = 32'd100;
        b     = 32'd7;
        step();
        start = 1'b0;
        wait_done("start busy", 35, 32'h1, 32'h2345_6780);
        count_done(40, nd);
        check("start busy extra done", nd, 0);

        issue(3'b000, 32'd7, 32'd9);
        while (cyc < 10) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush run busy", busy, 1'b0);
        count_done(40, nd);
        check("flush run done", nd, 0);
        check("flush run hi", hi, 32'h1);
        check("flush run lo", lo, 32'h2345_6780);

        issue(3'b001, 32'd3, 32'd3);
        while (cyc < 34) step();
        check("fix busy", busy, 1'b1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush fix ctl", {busy, done}, 2'b00);
        count_done(5, nd);
        check("flush fix done", nd, 0);
        check("flush fix hi", hi, 32'h1);
        check("flush fix lo", lo, 32'h2345_6780);

        issue(3'b010, 32'd1000, 32'd3);
        while (cyc < 20) step();
        #2 rst_n = 1'b0;
        #1;
        check("rst mid ctl", {busy, done, div0}, 3'b000);
        check("rst mid hi", hi, 32'h0);
        check("rst mid lo", lo, 32'h0);
        check("rst mid w", {hi_w, lo_w}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("rst mid idle", busy, 1'b0);

        issue(3'b010, 32'd1000, 32'd3);
        wait_done("div after rst", 35, 32'd1, 32'd333);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
